// File: rtl/tmul_pkg.sv
// Shared types and default sizing for the unipolar temporal-coded multiplier.
package tmul_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int LANES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/tmul_uni_lane.sv
// One multiplier lane: holds its rate operand, compares it against the shared
// RNG sample and counts the ones of the resulting bitstream.
module tmul_uni_lane
  import tmul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] rng_in,
  output logic             bit_out,
  output logic [WIDTH-1:0] acc_out
);

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    bit_out = en && (b_q > rng_in);
    b_d     = load ? b_in : b_q;
    acc_d   = acc_q;
    // The window never exceeds 2^WIDTH-1 cycles, so the count cannot wrap.
    if (clear) begin
      acc_d = '0;
    end else if (bit_out) begin
      acc_d = acc_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign acc_out = acc_q;

endmodule

// File: rtl/tmul_uni_acc.sv
// Multi-lane unipolar stochastic multiplier: operand A sets a shared time
// window, each lane counts ones of (B > rng) to estimate A*B/2^WIDTH.
//
// state   | meaning
// IDLE    | waiting for start; outputs hold the last counts
// RUN     | window open; RNG advances, lanes compare and count
// DONE    | one-cycle completion pulse, then back to IDLE
module tmul_uni_acc
  import tmul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LANES = LANES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [WIDTH-1:0]       a_in,
  input  logic [LANES*WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0]       rng_in,
  output logic                   rng_req,
  output logic [LANES-1:0]       bit_out,
  output logic [LANES*WIDTH-1:0] acc_out,
  output logic                   busy,
  output logic                   done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;

  assign accept  = (state_q == ST_IDLE) && start;
  assign rng_req = (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = a_in;
          state_d = (a_in != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        // abort outranks the final-cycle transition
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
          if (cnt_q == WIDTH'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    tmul_uni_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .clear   (accept),
      .en      (rng_req),
      .b_in    (b_in[i*WIDTH +: WIDTH]),
      .rng_in  (rng_in),
      .bit_out (bit_out[i]),
      .acc_out (acc_out[i*WIDTH +: WIDTH])
    );
  end

endmodule
